// File: rtl/simple_mem_pkg.sv
// Shared types and defaults for the memory port arbiter and its return tracker.
// Owner codes identify which requester a returning access belongs to.
package simple_mem_pkg;

    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 16;

    typedef enum logic {
        OWN_FETCH = 1'b0,
        OWN_DATA  = 1'b1
    } owner_e;

    // One slot of the return pipeline: an access granted READ_LATENCY cycles earlier.
    typedef struct packed {
        logic   vld;
        owner_e owner;
        logic   is_write;
    } trk_entry_t;

    localparam int TRK_ENTRY_W = $bits(trk_entry_t);

endpackage : simple_mem_pkg

// File: rtl/mem_return_tracker.sv
// Fixed-depth shift register that follows each granted access until its memory
// read data is due, then presents owner and access type at the tail.
module mem_return_tracker
    import simple_mem_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic   clock,
    input  logic   resetN,
    input  logic   push_i,
    input  owner_e push_owner_i,
    input  logic   push_is_write_i,
    output logic   tail_vld_o,
    output owner_e tail_owner_o,
    output logic   tail_is_write_o,
    output logic   any_vld_o
);

    trk_entry_t stage_q [DEPTH];
    trk_entry_t stage_d [DEPTH];

    always_comb begin
        stage_d[0].vld      = push_i;
        stage_d[0].owner    = push_owner_i;
        stage_d[0].is_write = push_i & push_is_write_i;
        for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    // Reset drops every in-flight access so none of them returns afterwards.
    always_ff @(posedge clock) begin
        if (!resetN) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    always_comb begin
        any_vld_o = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            any_vld_o = any_vld_o | stage_q[i].vld;
        end
    end

    assign tail_vld_o      = stage_q[DEPTH-1].vld;
    assign tail_owner_o    = stage_q[DEPTH-1].owner;
    assign tail_is_write_o = stage_q[DEPTH-1].is_write;

endmodule : mem_return_tracker

// File: rtl/memory_port_arbiter.sv
// Shares one single-port synchronous memory between instruction fetch and load/store.
// Data side wins contention; a starvation counter forces a fetch grant after STARVE_LIMIT losses.
module memory_port_arbiter
    import simple_mem_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int READ_LATENCY = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clock,
    input  logic              resetN,
    input  logic              fReq,
    input  logic [ADDR_W-1:0] fAddr,
    output logic              fGnt,
    output logic              fValid,
    output logic [DATA_W-1:0] fRdata,
    input  logic              dReq,
    input  logic              dWe,
    input  logic [ADDR_W-1:0] dAddr,
    input  logic [DATA_W-1:0] dWdata,
    output logic              dGnt,
    output logic              dValid,
    output logic [DATA_W-1:0] dRdata,
    output logic [ADDR_W-1:0] memAddress,
    output logic [DATA_W-1:0] memData,
    output logic              memWren,
    input  logic [DATA_W-1:0] memQ,
    output logic              busy
);

    localparam int                CNT_W      = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0]  starve_q, starve_d;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] f_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;

    logic   f_gnt, d_gnt, any_gnt;
    logic   tail_vld, tail_is_write, any_vld;
    owner_e tail_owner;
    logic   f_ret, d_ret, d_load_ret;

    // Handshake: a requester holds xReq and its fields stable until xGnt; xReq & xGnt
    // in the same cycle is the accepted transfer. Grants are never raised without a request.
    always_comb begin
        f_gnt = 1'b0;
        d_gnt = 1'b0;
        if (resetN) begin
            if (dReq && !(fReq && starve_q == STARVE_MAX)) begin
                d_gnt = 1'b1;
            end else if (fReq) begin
                f_gnt = 1'b1;
            end
        end
    end

    assign any_gnt = f_gnt | d_gnt;

    always_comb begin
        starve_d = starve_q;
        if (!fReq || f_gnt) begin
            starve_d = '0;
        end else if (starve_q != STARVE_MAX) begin
            starve_d = starve_q + CNT_W'(1);
        end
    end

    mem_return_tracker #(
        .DEPTH (READ_LATENCY)
    ) u_tracker (
        .clock           (clock),
        .resetN          (resetN),
        .push_i          (any_gnt),
        .push_owner_i    (d_gnt ? OWN_DATA : OWN_FETCH),
        .push_is_write_i (d_gnt & dWe),
        .tail_vld_o      (tail_vld),
        .tail_owner_o    (tail_owner),
        .tail_is_write_o (tail_is_write),
        .any_vld_o       (any_vld)
    );

    // Returns are masked during reset so an access dropped by reset never surfaces.
    assign f_ret      = resetN & tail_vld & (tail_owner == OWN_FETCH);
    assign d_ret      = resetN & tail_vld & (tail_owner == OWN_DATA);
    assign d_load_ret = d_ret & ~tail_is_write;

    always_ff @(posedge clock) begin
        if (!resetN) begin
            starve_q  <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            f_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            starve_q <= starve_d;
            if (d_gnt) begin
                addr_q <= dAddr;
                data_q <= dWdata;
            end else if (f_gnt) begin
                addr_q <= fAddr;
            end
            if (f_ret) begin
                f_rdata_q <= memQ;
            end
            if (d_load_ret) begin
                d_rdata_q <= memQ;
            end
        end
    end

    always_comb begin
        memAddress = '0;
        memData    = '0;
        memWren    = 1'b0;
        fRdata     = '0;
        dRdata     = '0;
        if (resetN) begin
            memAddress = d_gnt ? dAddr : (f_gnt ? fAddr : addr_q);
            memData    = d_gnt ? dWdata : data_q;
            memWren    = d_gnt & dWe;
            fRdata     = f_ret ? memQ : f_rdata_q;
            dRdata     = d_load_ret ? memQ : d_rdata_q;
        end
    end

    assign fGnt   = f_gnt;
    assign dGnt   = d_gnt;
    assign fValid = f_ret;
    assign dValid = d_ret;
    assign busy   = resetN & any_vld;

    a_one_grant : assert property (@(posedge clock) !(fGnt && dGnt));
    a_f_gnt_req : assert property (@(posedge clock) fGnt |-> fReq);
    a_d_gnt_req : assert property (@(posedge clock) dGnt |-> dReq);

endmodule : memory_port_arbiter

// File: tb/tb_memory_port_arbiter.sv
// Directed bench for memory_port_arbiter with a small synchronous memory model.
// Inputs change just after the falling edge; outputs are checked 1 time unit later.
module tb_memory_port_arbiter;

    localparam int RL = 2;

    logic        clock;
    logic        resetN;
    logic        fReq;
    logic [15:0] fAddr;
    logic        fGnt, fValid;
    logic [15:0] fRdata;
    logic        dReq, dWe;
    logic [15:0] dAddr, dWdata;
    logic        dGnt, dValid;
    logic [15:0] dRdata;
    logic [15:0] memAddress, memData;
    logic        memWren;
    logic [15:0] memQ;
    logic        busy;

    int checks;
    int failures;

    logic [15:0] mem [256];
    logic [15:0] rd_q [RL];

    bit          exp_fv   [7] = '{0, 0, 1, 0, 1, 0, 0};
    bit          exp_dv   [7] = '{0, 0, 0, 1, 0, 1, 0};
    bit          exp_busy [7] = '{0, 1, 1, 1, 1, 1, 0};
    logic [15:0] exp_rd   [7] = '{16'h0, 16'h0, 16'hA001, 16'hA002, 16'hA003, 16'hA004, 16'h0};

    memory_port_arbiter #(
        .ADDR_W       (16),
        .DATA_W       (16),
        .READ_LATENCY (RL),
        .STARVE_LIMIT (4)
    ) dut (
        .clock      (clock),
        .resetN     (resetN),
        .fReq       (fReq),
        .fAddr      (fAddr),
        .fGnt       (fGnt),
        .fValid     (fValid),
        .fRdata     (fRdata),
        .dReq       (dReq),
        .dWe        (dWe),
        .dAddr      (dAddr),
        .dWdata     (dWdata),
        .dGnt       (dGnt),
        .dValid     (dValid),
        .dRdata     (dRdata),
        .memAddress (memAddress),
        .memData    (memData),
        .memWren    (memWren),
        .memQ       (memQ),
        .busy       (busy)
    );

    // clock/reset block
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // memory model: write on wren, read data appears RL cycles after the address cycle
    always @(posedge clock) begin
        if (memWren) mem[memAddress[7:0]] <= memData;
        rd_q[0] <= mem[memAddress[7:0]];
        for (int i = 1; i < RL; i++) rd_q[i] <= rd_q[i-1];
    end
    assign memQ = rd_q[RL-1];

    task automatic next_cycle();
        @(negedge clock);
    endtask

    task automatic idle(input int n);
        fReq = 1'b0;
        dReq = 1'b0;
        dWe  = 1'b0;
        repeat (n) next_cycle();
    endtask

    task automatic test_reset();
        resetN = 1'b0;
        fReq = 1'b0; dReq = 1'b0; dWe = 1'b0;
        fAddr = '0; dAddr = '0; dWdata = '0;
        next_cycle();
        next_cycle();
        #1;
        checks++;
        if ({fGnt, dGnt, fValid, dValid, memWren, busy} !== 6'b0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=000000", {fGnt, dGnt, fValid, dValid, memWren, busy});
        end
        checks++;
        if ({fRdata, dRdata, memAddress, memData} !== 64'h0) begin
            failures++;
            $display("FAIL reset_data got=%h exp=0", {fRdata, dRdata, memAddress, memData});
        end
        next_cycle();
        resetN = 1'b1;
        #1;
        checks++;
        if ({fGnt, dGnt, busy, memAddress} !== 19'h0) begin
            failures++;
            $display("FAIL post_reset got=%h exp=0", {fGnt, dGnt, busy, memAddress});
        end
    endtask

    task automatic test_fetch_only();
        next_cycle();
        fReq = 1'b1; fAddr = 16'h0010;
        #1;
        checks++;
        if ({fGnt, dGnt, memWren} !== 3'b100) begin
            failures++;
            $display("FAIL fetch_gnt got=%b exp=100", {fGnt, dGnt, memWren});
        end
        checks++;
        if (memAddress !== 16'h0010) begin
            failures++;
            $display("FAIL fetch_addr got=%h exp=0010", memAddress);
        end
        next_cycle();
        fReq = 1'b0;
        #1;
        checks++;
        if ({fValid, busy} !== 2'b01) begin
            failures++;
            $display("FAIL fetch_wait got=%b exp=01", {fValid, busy});
        end
        next_cycle();
        #1;
        checks++;
        if ({fValid, dValid} !== 2'b10 || fRdata !== 16'hA010) begin
            failures++;
            $display("FAIL fetch_ret got=%b/%h exp=10/a010", {fValid, dValid}, fRdata);
        end
        next_cycle();
        #1;
        checks++;
        if ({fValid, busy} !== 2'b00 || fRdata !== 16'hA010) begin
            failures++;
            $display("FAIL fetch_hold got=%b/%h exp=00/a010", {fValid, busy}, fRdata);
        end
    endtask

    task automatic test_store_load();
        next_cycle();
        dReq = 1'b1; dWe = 1'b1; dAddr = 16'h0020; dWdata = 16'hBEEF;
        #1;
        checks++;
        if ({dGnt, fGnt, memWren} !== 3'b101 || memData !== 16'hBEEF || memAddress !== 16'h0020) begin
            failures++;
            $display("FAIL store_gnt got=%b/%h/%h exp=101/beef/0020", {dGnt, fGnt, memWren}, memData, memAddress);
        end
        next_cycle();
        dWe = 1'b0;
        #1;
        checks++;
        if ({dGnt, memWren} !== 2'b10) begin
            failures++;
            $display("FAIL load_gnt got=%b exp=10", {dGnt, memWren});
        end
        next_cycle();
        dReq = 1'b0;
        #1;
        checks++;
        if ({dValid, memWren} !== 2'b10 || dRdata !== 16'h0000) begin
            failures++;
            $display("FAIL store_done got=%b/%h exp=10/0000", {dValid, memWren}, dRdata);
        end
        next_cycle();
        #1;
        checks++;
        if (dValid !== 1'b1 || dRdata !== 16'hBEEF) begin
            failures++;
            $display("FAIL load_ret got=%b/%h exp=1/beef", dValid, dRdata);
        end
        next_cycle();
        #1;
        checks++;
        if (dValid !== 1'b0 || dRdata !== 16'hBEEF) begin
            failures++;
            $display("FAIL load_hold got=%b/%h exp=0/beef", dValid, dRdata);
        end
    endtask

    task automatic test_contention();
        idle(3);
        fReq = 1'b1; fAddr = 16'h0030;
        dReq = 1'b1; dWe = 1'b0; dAddr = 16'h0040;
        for (int i = 0; i < 10; i++) begin
            #1;
            checks++;
            if ({fGnt, dGnt} !== ((i % 5 == 4) ? 2'b10 : 2'b01)) begin
                failures++;
                $display("FAIL contention_%0d got=%b exp=%b", i, {fGnt, dGnt}, (i % 5 == 4) ? 2'b10 : 2'b01);
            end
            next_cycle();
        end
        idle(3);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 7; i++) begin
            fReq = (i < 4) && (i % 2 == 0);
            dReq = (i < 4) && (i % 2 == 1);
            dWe  = 1'b0;
            fAddr = 16'(i + 1);
            dAddr = 16'(i + 1);
            #1;
            checks++;
            if ({fGnt, dGnt} !== {fReq, dReq}) begin
                failures++;
                $display("FAIL b2b_gnt_%0d got=%b exp=%b", i, {fGnt, dGnt}, {fReq, dReq});
            end
            checks++;
            if ({fValid, dValid, busy} !== {exp_fv[i], exp_dv[i], exp_busy[i]}) begin
                failures++;
                $display("FAIL b2b_vld_%0d got=%b exp=%b", i, {fValid, dValid, busy}, {exp_fv[i], exp_dv[i], exp_busy[i]});
            end
            if (exp_fv[i]) begin
                checks++;
                if (fRdata !== exp_rd[i]) begin
                    failures++;
                    $display("FAIL b2b_frd_%0d got=%h exp=%h", i, fRdata, exp_rd[i]);
                end
            end
            if (exp_dv[i]) begin
                checks++;
                if (dRdata !== exp_rd[i]) begin
                    failures++;
                    $display("FAIL b2b_drd_%0d got=%h exp=%h", i, dRdata, exp_rd[i]);
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_reset_midflight();
        idle(2);
        dReq = 1'b1; dWe = 1'b0; dAddr = 16'h0005;
        #1;
        checks++;
        if (dGnt !== 1'b1) begin
            failures++;
            $display("FAIL mid_gnt got=%b exp=1", dGnt);
        end
        next_cycle();
        dReq = 1'b0;
        resetN = 1'b0;
        #1;
        checks++;
        if ({fGnt, dGnt, fValid, dValid, memWren, busy} !== 6'b0
            || {fRdata, dRdata, memAddress, memData} !== 64'h0) begin
            failures++;
            $display("FAIL mid_rst got=%b/%h exp=0/0", {fGnt, dGnt, fValid, dValid, memWren, busy},
                     {fRdata, dRdata, memAddress, memData});
        end
        next_cycle();
        resetN = 1'b1;
        #1;
        checks++;
        if ({dValid, busy} !== 2'b00 || dRdata !== 16'h0000) begin
            failures++;
            $display("FAIL mid_drop got=%b/%h exp=00/0000", {dValid, busy}, dRdata);
        end
        next_cycle();
        #1;
        checks++;
        if (dValid !== 1'b0) begin
            failures++;
            $display("FAIL mid_late got=%b exp=0", dValid);
        end
    endtask

    task automatic test_idle_hold();
        next_cycle();
        fReq = 1'b1; fAddr = 16'h0042;
        #1;
        checks++;
        if (fGnt !== 1'b1) begin
            failures++;
            $display("FAIL hold_gnt got=%b exp=1", fGnt);
        end
        next_cycle();
        fReq = 1'b0;
        fAddr = 16'h0077;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (memAddress !== 16'h0042 || {memWren, fGnt, dGnt} !== 3'b000) begin
                failures++;
                $display("FAIL hold_%0d got=%h/%b exp=0042/000", i, memAddress, {memWren, fGnt, dGnt});
            end
            next_cycle();
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        for (int i = 0; i < 256; i++) mem[i] = 16'hA000 | 16'(i);
        for (int i = 0; i < RL; i++) rd_q[i] = '0;
        test_reset();
        test_fetch_only();
        test_store_load();
        test_contention();
        test_back_to_back();
        test_reset_midflight();
        test_idle_hold();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_memory_port_arbiter
